car_sensor_cond: RTL and testbench

- Conditions the raw side-road vehicle sensor into the clean `cs` request level consumed by the main/side-road light controller.
- Stages: 2-flop synchroniser, then debouncer, then request FSM with hold-over.
- Also produces an 8-bit waiting-time counter in seconds, which the 7-segment `show` stage displays.
- Sits directly upstream of the light controller; all logic runs in the `clk` domain.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/car_sensor_cond_sync_debounce.sv | 51 +++++
 rtl/car_sensor_cond.sv | 165 ++++++++++++++++
 tb/tb_car_sensor_cond.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and timing constants for the side-road sensor path and the light controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: request FSM state enum, wait counter width/limit, default timing constants,
// saturating increment helper for the wait counter.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } req_state_e;

  localparam int                WAIT_W   = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = 8'd255;

  // Sensor conditioning defaults
  localparam int TICK_DIV_DEF    = 50_000_000;
  localparam int DEB_CYCLES_DEF  = 8;
  localparam int HOLD_TICKS_DEF  = 3;
  localparam int STUCK_TICKS_DEF = 120;

  // Light controller phase lengths in seconds
  localparam int MAIN_GREEN_S  = 25;
  localparam int MAIN_YELLOW_S = 5;
  localparam int SIDE_GREEN_S  = 16;
  localparam int SIDE_YELLOW_S = 5;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/car_sensor_cond_sync_debounce.sv
// 2-flop synchroniser followed by a consecutive-sample debouncer.
// Latency: raw edge to level change is 2 + DEB_CYCLES clk cycles.
// Backpressure: none, free-running level path.
// Ports: clk, rst_n (async active-low), raw (asynchronous input), level (debounced output).
module sync_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt tracks how many consecutive synchronised samples disagree with the
  // current level; any agreeing sample restarts the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/car_sensor_cond.sv
// Turns the raw side-road loop sensor into the registered cs request level plus a waiting-time counter.
// Latency: raw edge to present 2+DEB_CYCLES cycles, present to cs +1 cycle; wait_cnt updates one cycle after tick.
// Backpressure: none; srv_ack is a one-cycle pulse that is always accepted.
// Ports: clk, rst_n (async active-low), sensor_raw, srv_ack in; cs, present, wait_cnt[7:0], tick, sensor_fault out.
// Optional: define CAR_SENSOR_STUCK_DET_EN to enable stuck-sensor detection (STUCK_TICKS); otherwise sensor_fault is 0.
module car_sensor_cond
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
`ifdef CAR_SENSOR_STUCK_DET_EN
  , parameter int STUCK_TICKS = STUCK_TICKS_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sensor_raw,
  input  logic              srv_ack,
  output logic              cs,
  output logic              present,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              tick,
  output logic              sensor_fault
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD_TICKS - 1);

  logic              present_w;
  logic              tick_w;
  logic              force_idle;
  logic [PW-1:0]     pre_q, pre_d;
  req_state_e        state_q;
  logic [7:0]        hold_cnt_q;
  logic              cs_q;
  logic [WAIT_W-1:0] wait_q, wait_d;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sync_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sensor_raw),
    .level (present_w)
  );

  // Free-running 1 s prescaler; tick is the last count of each period.
  assign tick_w = (pre_q == PRE_LAST);
  assign pre_d  = tick_w ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

`ifdef CAR_SENSOR_STUCK_DET_EN
  localparam int            SW         = $clog2(STUCK_TICKS + 1);
  localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_TICKS);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_TICKS - 1);

  logic [SW-1:0] stuck_q, stuck_d;
  logic          fault_q, fault_d;

  // The counter saturates once the fault is declared, so the fault persists
  // until presence drops rather than re-arming.
  always_comb begin
    stuck_d = stuck_q;
    fault_d = fault_q;
    if (!present_w) begin
      stuck_d = '0;
      fault_d = 1'b0;
    end else if (tick_w && (stuck_q != STUCK_MAX)) begin
      stuck_d = stuck_q + SW'(1);
      if (stuck_q == STUCK_LAST) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q <= '0;
      fault_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
      fault_q <= fault_d;
    end
  end

  // fault_d covers both the declaring cycle and every cycle the fault is held.
  assign force_idle   = fault_d;
  assign sensor_fault = fault_q;
`else
  assign force_idle   = 1'b0;
  assign sensor_fault = 1'b0;
`endif

  // Request FSM; cs is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      cs_q       <= 1'b0;
    end else if (force_idle) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      cs_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (present_w) begin
            state_q <= REQ;
            cs_q    <= 1'b1;
          end
        end
        // An ack here only clears wait_cnt: the vehicle is still there.
        REQ: begin
          if (!present_w) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
          end
        end
        HOLD: begin
          if (srv_ack) begin
            state_q <= IDLE;
            cs_q    <= 1'b0;
          end else if (present_w) begin
            state_q    <= REQ;
            hold_cnt_q <= '0;
          end else if (tick_w) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q <= IDLE;
              cs_q    <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cs_q    <= 1'b0;
        end
      endcase
    end
  end

  // Clear has priority over a coincident tick.
  always_comb begin
    wait_d = wait_q;
    if ((state_q == IDLE) || srv_ack || force_idle) begin
      wait_d = '0;
    end else if (tick_w && cs_q) begin
      wait_d = sat_inc(wait_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  assign cs       = cs_q;
  assign present  = present_w;
  assign wait_cnt = wait_q;
  assign tick     = tick_w;

endmodule

// File: tb/tb_car_sensor_cond.sv
`timescale 1ns/1ps
module tb_car_sensor_cond;

  localparam int TD   = 4;
  localparam int DEB  = 3;
  localparam int HOLD = 2;
`ifdef CAR_SENSOR_STUCK_DET_EN
  localparam int STUCK  = 10;
  localparam int ACK_AT = 5;
`else
  localparam int ACK_AT = 7;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_raw = 1'b0;
  logic       srv_ack = 1'b0;
  logic       cs, present, tick, sensor_fault;
  logic [7:0] wait_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  car_sensor_cond #(
    .TICK_DIV   (TD),
    .DEB_CYCLES (DEB),
    .HOLD_TICKS (HOLD)
`ifdef CAR_SENSOR_STUCK_DET_EN
    , .STUCK_TICKS (STUCK)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor_raw   (sensor_raw),
    .srv_ack      (srv_ack),
    .cs           (cs),
    .present      (present),
    .wait_cnt     (wait_cnt),
    .tick         (tick),
    .sensor_fault (sensor_fault)
  );

  // ---------------- behavioural model ----------------
  // present: toggles once the last DEB synchronised samples all disagree with it.
  // mode: 0 idle, 1 requesting, 2 holding after the vehicle left.
  bit m_s1, m_s2;
  bit m_win[$];
  bit m_present, m_cs, m_fault;
  int m_pre, m_mode, m_hold_ticks, m_wait, m_stuck;

  always @(posedge clk or negedge rst_n) begin
    bit p_old, t_old, cs_old, all_diff, frc;
    int mode_old;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_win.delete();
      m_present = 0; m_cs = 0; m_fault = 0;
      m_pre = 0; m_mode = 0; m_hold_ticks = 0; m_wait = 0; m_stuck = 0;
    end else begin
      p_old    = m_present;
      t_old    = (m_pre == TD - 1);
      cs_old   = m_cs;
      mode_old = m_mode;
      frc      = 0;

      m_win.push_back(m_s2);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      all_diff = (m_win.size() == DEB);
      foreach (m_win[i]) if (m_win[i] == p_old) all_diff = 0;
      if (all_diff) m_present = !p_old;
      m_s2 = m_s1;
      m_s1 = sensor_raw;
      m_pre = (m_pre + 1) % TD;

`ifdef CAR_SENSOR_STUCK_DET_EN
      if (!p_old) begin
        m_stuck = 0;
        m_fault = 0;
      end else if (t_old && m_stuck < STUCK) begin
        m_stuck = m_stuck + 1;
        if (m_stuck == STUCK) m_fault = 1;
      end
      frc = m_fault;
`endif

      if (mode_old == 0 || srv_ack || frc) m_wait = 0;
      else if (t_old && cs_old && m_wait < 255) m_wait = m_wait + 1;

      if (frc) m_mode = 0;
      else begin
        case (mode_old)
          0: if (p_old) m_mode = 1;
          1: if (!p_old) begin m_mode = 2; m_hold_ticks = 0; end
          default: begin
            if (srv_ack) m_mode = 0;
            else if (p_old) m_mode = 1;
            else if (t_old) begin
              m_hold_ticks = m_hold_ticks + 1;
              if (m_hold_ticks >= HOLD) m_mode = 0;
            end
          end
        endcase
      end
      m_cs = (m_mode != 0);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return present;
      1:       return cs;
      2:       return tick;
      default: return sensor_fault;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input logic v, input int lim);
    int b;
    b = 0;
    while (sel(which) !== v && b < lim) begin
      @(negedge clk);
      b++;
    end
    total++;
    if (sel(which) !== v) begin
      bad++;
      $display("FAIL %s: still %b after %0d cycles, wanted %b", name, sel(which), lim, v);
    end
  endtask

  // Model-vs-DUT compare on every cycle.
  always @(negedge clk) begin
    check("cs",       cs,           m_cs);
    check("present",  present,      m_present);
    check("tick",     tick,         (m_pre == TD - 1));
    check("wait_cnt", wait_cnt,     m_wait);
    check("fault",    sensor_fault, m_fault);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n, b;

    repeat (3) @(negedge clk);
    check("rst_cs",      cs,           0);
    check("rst_present", present,      0);
    check("rst_wait",    wait_cnt,     0);
    check("rst_tick",    tick,         0);
    check("rst_fault",   sensor_fault, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 2-cycle glitch is filtered out
    sensor_raw = 1'b1;
    repeat (2) @(negedge clk);
    sensor_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("glitch_present", present, 0);
      check("glitch_cs",      cs,      0);
    end

    // held presence: present after 5 cycles, cs one later
    sensor_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("lat_present", present, (i >= 5));
      check("lat_cs",      cs,      (i >= 6));
    end
    for (int k = 1; k <= 3; k++) begin
      wait_sig("tick_wait", 2, 1'b1, 20);
      @(negedge clk);
      check("wait_step", wait_cnt, k);
    end

    // vehicle leaves and returns after one tick in HOLD: cs never drops
    wait_sig("tick_align", 2, 1'b1, 20);
    sensor_raw = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 6) sensor_raw = 1'b1;
      check("ret_cs", cs, 1);
      if (i == 8) check("ret_left", present, 0);
    end

    // vehicle leaves for good: two ticks of hold-over
    sensor_raw = 1'b0;
    wait_sig("leave_present", 0, 1'b0, 20);
    n = 0;
    b = 0;
    do begin
      @(negedge clk);
      b++;
      if (cs === 1'b1 && tick === 1'b1) n++;
    end while (cs === 1'b1 && b < 40);
    check("hold_ticks",   n,  2);
    check("hold_cs_drop", cs, 0);
    @(negedge clk);
    check("idle_wait", wait_cnt, 0);

    // srv_ack coincident with tick clears wait_cnt, cs stays in REQ
    sensor_raw = 1'b1;
    b = 0;
    while (wait_cnt !== 8'(ACK_AT) && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("reach_ack_at", wait_cnt, ACK_AT);
    wait_sig("tick_ack", 2, 1'b1, 20);
    check("pre_ack_wait", wait_cnt, ACK_AT);
    srv_ack = 1'b1;
    @(negedge clk);
    srv_ack = 1'b0;
    check("ack_tick_clear", wait_cnt, 0);
    check("ack_req_cs",     cs,       1);

    // srv_ack in HOLD ends the request at once
    sensor_raw = 1'b0;
    wait_sig("ackhold_present", 0, 1'b0, 20);
    @(negedge clk);
    check("hold_cs", cs, 1);
    srv_ack = 1'b1;
    @(negedge clk);
    srv_ack = 1'b0;
    check("ack_hold_cs", cs, 0);

    // srv_ack in IDLE is ignored
    repeat (3) @(negedge clk);
    srv_ack = 1'b1;
    @(negedge clk);
    srv_ack = 1'b0;
    check("idle_ack_cs", cs, 0);
    @(negedge clk);
    check("idle_ack_wait", wait_cnt, 0);

    // asynchronous reset mid-request
    sensor_raw = 1'b1;
    wait_sig("pre_rst_cs", 1, 1'b1, 30);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs",      cs,       0);
    check("arst_present", present,  0);
    check("arst_wait",    wait_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CAR_SENSOR_STUCK_DET_EN
    // stuck detection: fault after the 10th tick of presence
    n = 0;
    b = 0;
    while (sensor_fault !== 1'b1 && b < 200) begin
      if (present === 1'b1 && tick === 1'b1) n++;
      @(negedge clk);
      b++;
    end
    check("stuck_ticks", n,            10);
    check("stuck_fault", sensor_fault, 1);
    check("stuck_cs",    cs,           0);
    repeat (10) @(negedge clk);
    check("stuck_keep_fault", sensor_fault, 1);
    check("stuck_keep_cs",    cs,           0);
    check("stuck_keep_wait",  wait_cnt,     0);
    sensor_raw = 1'b0;
    wait_sig("stuck_present", 0, 1'b0, 20);
    check("fault_until_absent", sensor_fault, 1);
    @(negedge clk);
    check("fault_cleared", sensor_fault, 0);
    sensor_raw = 1'b1;
    wait_sig("resume_cs", 1, 1'b1, 30);
`else
    // saturation after 300 ticks of presence
    for (int k = 0; k < 300; k++) begin
      wait_sig("sat_tick", 2, 1'b1, 20);
      @(negedge clk);
    end
    check("sat_wait", wait_cnt, 255);
    check("sat_cs",   cs,       1);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
